// File: rtl/ddr_arb_pkg.sv
// Shared types and sizing helpers for the 2:1 DDR AXI arbiter.
// Requester index is one bit; it becomes the MSB of the downstream ID.
package ddr_arb_pkg;

   typedef logic req_idx_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_DATA = 1'b1
   } wr_state_e;

   localparam int unsigned REQ_IDX_WIDTH = 1;

   function automatic int unsigned down_id_width(input int unsigned id_width);
      return id_width + REQ_IDX_WIDTH;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

endpackage

// File: rtl/ddr_arb_rr.sv
// Two-way round-robin arbiter. A presented grant that is not accepted is held
// until the downstream handshake so the address phase stays stable.
module ddr_arb_rr
   import ddr_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] eligible,
   input  logic       ready,
   output req_idx_t   grant_idx,
   output logic       grant_valid
);

   req_idx_t favour;
   req_idx_t held_idx;
   logic     held;

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_idx   = favour;
      grant_valid = held | (|eligible);
      if (held)
         grant_idx = held_idx;
      else if (eligible == 2'b10)
         grant_idx = 1'b1;
      else if (eligible == 2'b01)
         grant_idx = 1'b0;
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         favour   <= 1'b0;
         held     <= 1'b0;
         held_idx <= 1'b0;
      end else if (grant_valid) begin
         if (ready) begin
            favour <= ~grant_idx;
            held   <= 1'b0;
         end else begin
            held     <= 1'b1;
            held_idx <= grant_idx;
         end
      end
   end

endmodule

// File: rtl/ddr_axi_arbiter.sv
// 2:1 AXI4 arbiter sharing one DDR port between the PCIS DMA path (s0) and the
// Fletcher master (s1); requester index is prepended to the ID to route R/B back.
module ddr_axi_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int ID_WIDTH        = 6,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                      kcd_clk,
   input  logic                      kcd_reset,
   // requester 0
   input  logic                      s0_axi_awvalid,
   output logic                      s0_axi_awready,
   input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
   input  logic [ID_WIDTH-1:0]       s0_axi_awid,
   input  logic [7:0]                s0_axi_awlen,
   input  logic [2:0]                s0_axi_awsize,
   input  logic                      s0_axi_wvalid,
   output logic                      s0_axi_wready,
   input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
   input  logic                      s0_axi_wlast,
   output logic                      s0_axi_bvalid,
   input  logic                      s0_axi_bready,
   output logic [ID_WIDTH-1:0]       s0_axi_bid,
   output logic [1:0]                s0_axi_bresp,
   input  logic                      s0_axi_arvalid,
   output logic                      s0_axi_arready,
   input  logic [ADDR_WIDTH-1:0]     s0_axi_araddr,
   input  logic [ID_WIDTH-1:0]       s0_axi_arid,
   input  logic [7:0]                s0_axi_arlen,
   input  logic [2:0]                s0_axi_arsize,
   output logic                      s0_axi_rvalid,
   input  logic                      s0_axi_rready,
   output logic [DATA_WIDTH-1:0]     s0_axi_rdata,
   output logic [ID_WIDTH-1:0]       s0_axi_rid,
   output logic [1:0]                s0_axi_rresp,
   output logic                      s0_axi_rlast,
   // requester 1
   input  logic                      s1_axi_awvalid,
   output logic                      s1_axi_awready,
   input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
   input  logic [ID_WIDTH-1:0]       s1_axi_awid,
   input  logic [7:0]                s1_axi_awlen,
   input  logic [2:0]                s1_axi_awsize,
   input  logic                      s1_axi_wvalid,
   output logic                      s1_axi_wready,
   input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
   input  logic                      s1_axi_wlast,
   output logic                      s1_axi_bvalid,
   input  logic                      s1_axi_bready,
   output logic [ID_WIDTH-1:0]       s1_axi_bid,
   output logic [1:0]                s1_axi_bresp,
   input  logic                      s1_axi_arvalid,
   output logic                      s1_axi_arready,
   input  logic [ADDR_WIDTH-1:0]     s1_axi_araddr,
   input  logic [ID_WIDTH-1:0]       s1_axi_arid,
   input  logic [7:0]                s1_axi_arlen,
   input  logic [2:0]                s1_axi_arsize,
   output logic                      s1_axi_rvalid,
   input  logic                      s1_axi_rready,
   output logic [DATA_WIDTH-1:0]     s1_axi_rdata,
   output logic [ID_WIDTH-1:0]       s1_axi_rid,
   output logic [1:0]                s1_axi_rresp,
   output logic                      s1_axi_rlast,
   // DDR side
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [down_id_width(ID_WIDTH)-1:0] m_axi_awid,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wlast,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   input  logic [down_id_width(ID_WIDTH)-1:0] m_axi_bid,
   input  logic [1:0]                m_axi_bresp,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [down_id_width(ID_WIDTH)-1:0] m_axi_arid,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [down_id_width(ID_WIDTH)-1:0] m_axi_rid,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast
);

   localparam int CW = cnt_width(MAX_OUTSTANDING);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          run;
   logic [CW-1:0] rd_cnt [2];
   logic [CW-1:0] wr_cnt [2];
   logic [1:0]    ar_elig, aw_elig;
   req_idx_t      ar_gnt, aw_gnt, r_dst, b_dst, w_sel;
   logic          ar_gv, aw_gv, ar_fire, aw_fire;
   logic [1:0]    ar_hs, aw_hs, r_done, b_done;
   wr_state_e     wr_state;

   // Everything is forced quiet while reset is asserted, whatever the inputs do.
   assign run = ~kcd_reset;

   always_comb begin
      ar_elig = '0;
      aw_elig = '0;
      ar_elig[0] = s0_axi_arvalid && (rd_cnt[0] < CNT_MAX);
      ar_elig[1] = s1_axi_arvalid && (rd_cnt[1] < CNT_MAX);
      aw_elig[0] = s0_axi_awvalid && (wr_cnt[0] < CNT_MAX) && (wr_state == W_IDLE);
      aw_elig[1] = s1_axi_awvalid && (wr_cnt[1] < CNT_MAX) && (wr_state == W_IDLE);
   end

   ddr_arb_rr u_ar_rr (
      .clk         (kcd_clk),
      .reset       (kcd_reset),
      .eligible    (ar_elig),
      .ready       (m_axi_arready),
      .grant_idx   (ar_gnt),
      .grant_valid (ar_gv)
   );

   ddr_arb_rr u_aw_rr (
      .clk         (kcd_clk),
      .reset       (kcd_reset),
      .eligible    (aw_elig),
      .ready       (m_axi_awready),
      .grant_idx   (aw_gnt),
      .grant_valid (aw_gv)
   );

   // Read address
   assign m_axi_arvalid  = run & ar_gv;
   assign m_axi_araddr   = ar_gnt ? s1_axi_araddr : s0_axi_araddr;
   assign m_axi_arid     = {ar_gnt, (ar_gnt ? s1_axi_arid : s0_axi_arid)};
   assign m_axi_arlen    = ar_gnt ? s1_axi_arlen  : s0_axi_arlen;
   assign m_axi_arsize   = ar_gnt ? s1_axi_arsize : s0_axi_arsize;
   assign ar_fire        = m_axi_arvalid & m_axi_arready;
   assign ar_hs          = {ar_fire & ar_gnt, ar_fire & ~ar_gnt};
   assign s0_axi_arready = ar_hs[0];
   assign s1_axi_arready = ar_hs[1];

   // Read data: routed by the prepended requester bit, never arbitrated
   assign r_dst         = m_axi_rid[ID_WIDTH];
   assign m_axi_rready  = run & (r_dst ? s1_axi_rready : s0_axi_rready);
   assign s0_axi_rvalid = run & m_axi_rvalid & ~r_dst;
   assign s1_axi_rvalid = run & m_axi_rvalid &  r_dst;
   assign s0_axi_rdata  = m_axi_rdata;
   assign s1_axi_rdata  = m_axi_rdata;
   assign s0_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
   assign s1_axi_rid    = m_axi_rid[ID_WIDTH-1:0];
   assign s0_axi_rresp  = m_axi_rresp;
   assign s1_axi_rresp  = m_axi_rresp;
   assign s0_axi_rlast  = m_axi_rlast;
   assign s1_axi_rlast  = m_axi_rlast;
   assign r_done        = {2{m_axi_rvalid & m_axi_rready & m_axi_rlast}} & {r_dst, ~r_dst};

   // Write address
   assign m_axi_awvalid  = run & aw_gv;
   assign m_axi_awaddr   = aw_gnt ? s1_axi_awaddr : s0_axi_awaddr;
   assign m_axi_awid     = {aw_gnt, (aw_gnt ? s1_axi_awid : s0_axi_awid)};
   assign m_axi_awlen    = aw_gnt ? s1_axi_awlen  : s0_axi_awlen;
   assign m_axi_awsize   = aw_gnt ? s1_axi_awsize : s0_axi_awsize;
   assign aw_fire        = m_axi_awvalid & m_axi_awready;
   assign aw_hs          = {aw_fire & aw_gnt, aw_fire & ~aw_gnt};
   assign s0_axi_awready = aw_hs[0];
   assign s1_axi_awready = aw_hs[1];

   // Write data only flows in W_DATA, giving a one-cycle bubble after AW.
   assign m_axi_wvalid  = run & (wr_state == W_DATA) & (w_sel ? s1_axi_wvalid : s0_axi_wvalid);
   assign m_axi_wdata   = w_sel ? s1_axi_wdata : s0_axi_wdata;
   assign m_axi_wstrb   = w_sel ? s1_axi_wstrb : s0_axi_wstrb;
   assign m_axi_wlast   = w_sel ? s1_axi_wlast : s0_axi_wlast;
   assign s0_axi_wready = run & (wr_state == W_DATA) & ~w_sel & m_axi_wready;
   assign s1_axi_wready = run & (wr_state == W_DATA) &  w_sel & m_axi_wready;

   // Write response
   assign b_dst         = m_axi_bid[ID_WIDTH];
   assign m_axi_bready  = run & (b_dst ? s1_axi_bready : s0_axi_bready);
   assign s0_axi_bvalid = run & m_axi_bvalid & ~b_dst;
   assign s1_axi_bvalid = run & m_axi_bvalid &  b_dst;
   assign s0_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
   assign s1_axi_bid    = m_axi_bid[ID_WIDTH-1:0];
   assign s0_axi_bresp  = m_axi_bresp;
   assign s1_axi_bresp  = m_axi_bresp;
   assign b_done        = {2{m_axi_bvalid & m_axi_bready}} & {b_dst, ~b_dst};

   always_ff @(posedge kcd_clk) begin
      if (kcd_reset) begin
         wr_state <= W_IDLE;
         w_sel    <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE:  if (aw_fire) begin
                        wr_state <= W_DATA;
                        w_sel    <= aw_gnt;
                     end
            W_DATA:  if (m_axi_wvalid && m_axi_wready && m_axi_wlast)
                        wr_state <= W_IDLE;
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // Issue and retire in the same cycle cancel out.
   always_ff @(posedge kcd_clk) begin
      if (kcd_reset) begin
         for (int i = 0; i < 2; i++) begin
            rd_cnt[i] <= '0;
            wr_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case ({ar_hs[i], r_done[i]})
               2'b10:   rd_cnt[i] <= rd_cnt[i] + CNT_ONE;
               2'b01:   rd_cnt[i] <= rd_cnt[i] - CNT_ONE;
               default: rd_cnt[i] <= rd_cnt[i];
            endcase
            case ({aw_hs[i], b_done[i]})
               2'b10:   wr_cnt[i] <= wr_cnt[i] + CNT_ONE;
               2'b01:   wr_cnt[i] <= wr_cnt[i] - CNT_ONE;
               default: wr_cnt[i] <= wr_cnt[i];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Directed scenarios followed by a randomized read phase checked against a
// queue-based model of outstanding reads per requester.
module tb_ddr_axi_arbiter;

   localparam int AW = 32, DW = 64, IW = 6, MO = 2, SW = DW / 8, MIW = IW + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          awvalid [2], awready [2], wvalid [2], wready [2], wlast [2];
   logic          bvalid [2], bready [2], arvalid [2], arready [2];
   logic          rvalid [2], rready [2], rlast [2];
   logic [AW-1:0] awaddr [2], araddr [2];
   logic [IW-1:0] awid [2], bid [2], arid [2], rid [2];
   logic [7:0]    awlen [2], arlen [2];
   logic [2:0]    awsize [2], arsize [2];
   logic [DW-1:0] wdata [2], rdata [2];
   logic [SW-1:0] wstrb [2];
   logic [1:0]    bresp [2], rresp [2];

   logic           m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic           m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [AW-1:0]  m_awaddr, m_araddr;
   logic [MIW-1:0] m_awid, m_bid, m_arid, m_rid;
   logic [7:0]     m_awlen, m_arlen;
   logic [2:0]     m_awsize, m_arsize;
   logic [DW-1:0]  m_wdata, m_rdata;
   logic [SW-1:0]  m_wstrb;
   logic [1:0]     m_bresp, m_rresp;

   ddr_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
      .kcd_clk(clk), .kcd_reset(rst),
      .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]), .s0_axi_awaddr(awaddr[0]),
      .s0_axi_awid(awid[0]), .s0_axi_awlen(awlen[0]), .s0_axi_awsize(awsize[0]),
      .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]), .s0_axi_wdata(wdata[0]),
      .s0_axi_wstrb(wstrb[0]), .s0_axi_wlast(wlast[0]),
      .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]), .s0_axi_bid(bid[0]), .s0_axi_bresp(bresp[0]),
      .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]), .s0_axi_araddr(araddr[0]),
      .s0_axi_arid(arid[0]), .s0_axi_arlen(arlen[0]), .s0_axi_arsize(arsize[0]),
      .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]), .s0_axi_rdata(rdata[0]),
      .s0_axi_rid(rid[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rlast(rlast[0]),
      .s1_axi_awvalid(awvalid[1]), .s1_axi_awready(awready[1]), .s1_axi_awaddr(awaddr[1]),
      .s1_axi_awid(awid[1]), .s1_axi_awlen(awlen[1]), .s1_axi_awsize(awsize[1]),
      .s1_axi_wvalid(wvalid[1]), .s1_axi_wready(wready[1]), .s1_axi_wdata(wdata[1]),
      .s1_axi_wstrb(wstrb[1]), .s1_axi_wlast(wlast[1]),
      .s1_axi_bvalid(bvalid[1]), .s1_axi_bready(bready[1]), .s1_axi_bid(bid[1]), .s1_axi_bresp(bresp[1]),
      .s1_axi_arvalid(arvalid[1]), .s1_axi_arready(arready[1]), .s1_axi_araddr(araddr[1]),
      .s1_axi_arid(arid[1]), .s1_axi_arlen(arlen[1]), .s1_axi_arsize(arsize[1]),
      .s1_axi_rvalid(rvalid[1]), .s1_axi_rready(rready[1]), .s1_axi_rdata(rdata[1]),
      .s1_axi_rid(rid[1]), .s1_axi_rresp(rresp[1]), .s1_axi_rlast(rlast[1]),
      .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_awaddr(m_awaddr),
      .m_axi_awid(m_awid), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
      .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_wdata(m_wdata),
      .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
      .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
      .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(m_araddr),
      .m_axi_arid(m_arid), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
      .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rdata(m_rdata),
      .m_axi_rid(m_rid), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive just after the rising edge, compare two time units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   function automatic logic [14:0] all_vr();
      return {awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1],
              arready[0], arready[1], rvalid[0], rvalid[1],
              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
   endfunction

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         awvalid[i] = 0; awaddr[i] = '0; awid[i] = '0; awlen[i] = '0; awsize[i] = 3'd3;
         wvalid[i] = 0; wdata[i] = '0; wstrb[i] = '1; wlast[i] = 0; bready[i] = 0;
         arvalid[i] = 0; araddr[i] = '0; arid[i] = '0; arlen[i] = '0; arsize[i] = 3'd3;
         rready[i] = 0;
      end
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
      m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
   endtask

   // One single-beat read response from DDR, checked for routing and ID strip.
   task automatic r_beat(input int dst, input logic [IW-1:0] id);
      m_rvalid = 1; m_rid = {dst[0], id}; m_rlast = 1; m_rdata = {$urandom, $urandom};
      rready[0] = 1; rready[1] = 1;
      settle();
      chk("r_route", rvalid[dst], 1);
      chk("r_other", rvalid[1-dst], 0);
      chk("r_id", rid[dst], id);
      tick();
      m_rvalid = 0; m_rlast = 0;
   endtask

   // Model state for the randomized read phase
   logic [IW-1:0] rq0 [$];
   logic [IW-1:0] rq1 [$];

   initial begin
      int beat;
      int fav, held_i, g, r_dst;
      bit held, gv, e0, e1, r_pend, ar_fire, r_fire;
      logic [IW-1:0] r_id;

      rst = 1;
      idle_inputs();
      repeat (2) tick();
      settle();
      chk("reset_vr", all_vr(), '0);
      rst = 0;
      tick();
      settle();
      chk("post_reset_vr", all_vr(), '0);

      // Both requesters streaming reads: grants alternate until both saturate.
      tick();
      arvalid[0] = 1; arid[0] = 6'h03; araddr[0] = 32'h1000;
      arvalid[1] = 1; arid[1] = 6'h09; araddr[1] = 32'h2000;
      m_arready = 1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("ar_alt_id", m_arid, ((k % 2) << IW) | ((k % 2) ? 6'h09 : 6'h03));
         chk("ar_alt_addr", m_araddr, (k % 2) ? 32'h2000 : 32'h1000);
         chk("ar_alt_rdy", arready[k % 2], 1);
         chk("ar_alt_rdy_other", arready[1 - (k % 2)], 0);
         tick();
      end
      settle();
      chk("ar_sat_both", m_arvalid, 0);
      tick();
      arvalid[0] = 0; arvalid[1] = 0;
      // rid 7'h45 goes to s1 with rid 6'h05
      r_beat(1, 6'h05);
      r_beat(1, 6'h09);
      r_beat(0, 6'h03);
      r_beat(0, 6'h03);

      // One s0 read so the pointer favours s1, then stall DDR with s0 presented.
      arvalid[0] = 1; arid[0] = 6'h10; araddr[0] = 32'h3000;
      settle();
      chk("ar_pre_rdy", arready[0], 1);
      tick();
      arvalid[0] = 0;
      r_beat(0, 6'h10);
      arvalid[0] = 1; arid[0] = 6'h11; araddr[0] = 32'h3100; m_arready = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin arvalid[1] = 1; arid[1] = 6'h22; araddr[1] = 32'h4000; end
         settle();
         chk("ar_hold_id", m_arid, 7'h11);
         chk("ar_hold_addr", m_araddr, 32'h3100);
         chk("ar_hold_rdy", arready[0] | arready[1], 0);
         tick();
      end
      m_arready = 1;
      settle();
      chk("ar_hold_release", arready[0], 1);
      tick();
      arvalid[0] = 0;
      settle();
      chk("ar_next_id", m_arid, 7'h62);
      chk("ar_next_rdy", arready[1], 1);
      tick();
      arvalid[1] = 0;
      r_beat(0, 6'h11);
      r_beat(1, 6'h22);

      // Saturation at MAX_OUTSTANDING=2 for s0, released by one rlast.
      arvalid[0] = 1; arid[0] = 6'h01;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("ar_fill_rdy", arready[0], 1);
         tick();
      end
      settle();
      chk("ar_sat_rdy", arready[0], 0);
      chk("ar_sat_valid", m_arvalid, 0);
      tick();
      m_rvalid = 1; m_rid = 7'h01; m_rlast = 1; rready[0] = 1;
      settle();
      chk("ar_sat_during_r", arready[0], 0);
      tick();
      m_rvalid = 0; m_rlast = 0;
      settle();
      chk("ar_unsat_rdy", arready[0], 1);
      tick();
      arvalid[0] = 0;

      // rd_cnt[0]=2 -> 1, then AR and rlast together must leave it at 1.
      r_beat(0, 6'h01);
      arvalid[0] = 1; m_rvalid = 1; m_rid = 7'h01; m_rlast = 1; rready[0] = 1;
      settle();
      chk("same_cyc_ar", arready[0], 1);
      chk("same_cyc_r", rvalid[0], 1);
      tick();
      m_rvalid = 0; m_rlast = 0;
      settle();
      chk("same_cyc_after1", arready[0], 1);
      tick();
      settle();
      chk("same_cyc_after2", arready[0], 0);
      tick();
      arvalid[0] = 0;
      r_beat(0, 6'h01);
      r_beat(0, 6'h01);

      // s1 4-beat write, s0 AW arrives mid-burst and must wait for wlast.
      awvalid[1] = 1; awid[1] = 6'h2A; awlen[1] = 8'd3; awaddr[1] = 32'h8000;
      wvalid[1] = 1; wdata[1] = 64'hD0; m_awready = 1; m_wready = 1;
      settle();
      chk("aw_s1_rdy", awready[1], 1);
      chk("aw_s1_id", m_awid, 7'h6A);
      chk("aw_s1_len", m_awlen, 3);
      chk("w_idle_bubble", m_wvalid, 0);
      tick();
      awvalid[1] = 0;
      awvalid[0] = 1; awid[0] = 6'h15; awlen[0] = 8'd0; awaddr[0] = 32'h9000;
      beat = 0;
      for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
         m_wready = cyc[0];
         wdata[1] = 64'hD0 + 64'(beat);
         wlast[1] = (beat == 3);
         settle();
         chk("w_s0_aw_blocked", awready[0], 0);
         chk("w_m_awvalid", m_awvalid, 0);
         chk("w_m_wvalid", m_wvalid, 1);
         chk("w_data", m_wdata, 64'hD0 + 64'(beat));
         chk("w_s1_rdy", wready[1], cyc[0]);
         chk("w_s0_rdy", wready[0], 0);
         tick();
         if (cyc[0]) beat++;
      end
      chk("w_burst_beats", beat, 4);
      wvalid[1] = 0; wlast[1] = 0;
      settle();
      chk("aw_s0_after_wlast", awready[0], 1);
      chk("aw_s0_id", m_awid, 7'h15);
      tick();
      awvalid[0] = 0;
      wvalid[0] = 1; wlast[0] = 1; wdata[0] = 64'hEE; m_wready = 1;
      settle();
      chk("w_s0_rdy_burst", wready[0], 1);
      chk("w_s0_data", m_wdata, 64'hEE);
      tick();
      wvalid[0] = 0; wlast[0] = 0;
      m_bvalid = 1; m_bid = 7'h6A; bready[0] = 1; bready[1] = 1;
      settle();
      chk("b_s1_valid", bvalid[1], 1);
      chk("b_s0_quiet", bvalid[0], 0);
      chk("b_s1_id", bid[1], 6'h2A);
      chk("b_bready", m_bready, 1);
      tick();
      m_bid = 7'h15;
      settle();
      chk("b_s0_valid", bvalid[0], 1);
      chk("b_s0_id", bid[0], 6'h15);
      tick();
      m_bvalid = 0;

      // Fill wr_cnt[0] to 2 and sit in W_DATA, then reset with inputs active.
      for (int k = 0; k < 2; k++) begin
         awvalid[0] = 1; awid[0] = 6'(k);
         settle();
         chk("aw_fill_rdy", awready[0], 1);
         tick();
         awvalid[0] = 0;
         if (k == 0) begin
            wvalid[0] = 1; wlast[0] = 1;
            tick();
            wvalid[0] = 0; wlast[0] = 0;
         end
      end
      awvalid[0] = 1; awvalid[1] = 1; wvalid[0] = 1; arvalid[0] = 1;
      m_rvalid = 1; m_rid = 7'h00; m_bvalid = 1; m_arready = 1;
      rst = 1;
      settle();
      chk("rst_mid_burst_vr", all_vr(), '0);
      tick();
      rst = 0; wvalid[0] = 0; arvalid[0] = 0; m_rvalid = 0; m_bvalid = 0;
      settle();
      chk("post_rst_aw_s0", awready[0], 1);
      chk("post_rst_aw_s1", awready[1], 0);
      chk("post_rst_aw_id", m_awid[IW], 0);
      tick();
      awvalid[0] = 0; awvalid[1] = 0;
      wvalid[0] = 1; wlast[0] = 1;
      settle();
      chk("post_rst_w", wready[0], 1);
      tick();
      wvalid[0] = 0; wlast[0] = 0;

      // Randomized reads against per-requester outstanding queues.
      fav = 0; held = 0; held_i = 0; r_pend = 0; r_dst = 0; r_id = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 2; i++)
            if (!arvalid[i] && $urandom_range(2) == 0) begin
               arvalid[i] = 1; arid[i] = 6'($urandom); araddr[i] = $urandom; arlen[i] = 8'($urandom);
            end
         m_arready = ($urandom_range(3) != 0);
         if (!r_pend && (rq0.size() + rq1.size() > 0) && $urandom_range(1) == 1) begin
            r_dst = (rq0.size() == 0) ? 1 : (rq1.size() == 0) ? 0 : int'($urandom_range(1));
            r_id = r_dst ? rq1[0] : rq0[0];
            r_pend = 1;
            m_rdata = {$urandom, $urandom};
         end
         m_rvalid = r_pend; m_rid = {r_dst[0], r_id}; m_rlast = 1;
         rready[0] = 1'($urandom_range(1)); rready[1] = 1'($urandom_range(1));
         settle();
         e0 = arvalid[0] && rq0.size() < MO;
         e1 = arvalid[1] && rq1.size() < MO;
         if (held) begin gv = 1; g = held_i; end
         else begin gv = e0 || e1; g = (e0 && e1) ? fav : (e1 ? 1 : 0); end
         chk("rnd_arvalid", m_arvalid, gv);
         if (gv) begin
            chk("rnd_arid", m_arid, (g << IW) | arid[g]);
            chk("rnd_araddr", m_araddr, araddr[g]);
            chk("rnd_arlen", m_arlen, arlen[g]);
         end
         chk("rnd_arready0", arready[0], gv && g == 0 && m_arready);
         chk("rnd_arready1", arready[1], gv && g == 1 && m_arready);
         if (r_pend) begin
            chk("rnd_rvalid", rvalid[r_dst], 1);
            chk("rnd_rvalid_other", rvalid[1-r_dst], 0);
            chk("rnd_rid", rid[r_dst], r_id);
            chk("rnd_rdata", rdata[r_dst], m_rdata);
            chk("rnd_rready", m_rready, rready[r_dst]);
         end
         ar_fire = gv && m_arready;
         r_fire = r_pend && rready[r_dst];
         tick();
         if (ar_fire) begin
            if (g == 0) rq0.push_back(arid[0]); else rq1.push_back(arid[1]);
            arvalid[g] = 0; fav = 1 - g; held = 0;
         end else if (gv) begin
            held = 1; held_i = g;
         end
         if (r_fire) begin
            if (r_dst == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
            r_pend = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ddr_axi_arbiter.md
Name: ddr_axi_arbiter

Overview:
2:1 AXI4 full-protocol arbiter that shares the single DDR slave port between the DMA PCIS path (requester 0) and the Fletcher accelerator master (requester 1). Read and write channels are arbitrated independently with round-robin fairness. One ID bit is prepended to route R/B responses back to the issuing requester. Sits between the PCIS slave/interconnect and the shell DDR interface, in the kernel clock domain.

Parameters:
ADDR_WIDTH, 64, address width of all ports
DATA_WIDTH, 512, data width; strobe width is DATA_WIDTH/8
ID_WIDTH, 6, upstream ID width; downstream ID width is ID_WIDTH+1
MAX_OUTSTANDING, 16, max in-flight bursts per requester per direction (range 1..255)

Ports:
kcd_clk  in  1  clock
kcd_reset  in  1  synchronous reset, active-high
sN_axi_aw{valid,ready,addr,id,len,size}  slave (N=0,1)  1/1/ADDR/ID/8/3  write address
sN_axi_w{valid,ready,data,strb,last}  slave  1/1/DATA/DATA/8/1  write data
sN_axi_b{valid,ready,id,resp}  slave  1/1/ID/2  write response
sN_axi_ar{valid,ready,addr,id,len,size}  slave  1/1/ADDR/ID/8/3  read address
sN_axi_r{valid,ready,data,id,resp,last}  slave  1/1/DATA/ID/2/1  read data
m_axi_{aw,w,b,ar,r}*  master  same fields, id width ID_WIDTH+1  to DDR

Behaviour:
- Reset: all valid/ready outputs 0, write FSM W_IDLE, both RR pointers favour s0, all outstanding counters 0. Reset mid-burst abandons the burst; no recovery of in-flight transactions.
- Eligibility: sN eligible for AR if sN_axi_arvalid and rd_cnt[N] < MAX_OUTSTANDING; same for AW with wr_cnt[N].
- AR: combinational mux, zero added latency. Grant chosen when m_axi_arvalid is not stalled; while m_axi_arvalid && !m_axi_arready the grant is held (AXI stability). On handshake, pointer moves to favour the other requester. m_axi_arid = {N, sN_arid}. Only granted sN_axi_arready follows m_axi_arready; other is 0.
- R: route by m_axi_rid[ID_WIDTH]; sN_axi_rid = low ID_WIDTH bits; m_axi_rready = selected sN_axi_rready.
- Write FSM: W_IDLE -> grant AW per RR (same hold rule), m_axi_awid = {N, sN_awid}; AW handshake -> W_DATA(N). W_DATA: W channel of N passed through, other sN_axi_wready=0, no AW accepted; handshake with wlast=1 -> W_IDLE. W is never forwarded in W_IDLE (one-cycle bubble AW->W by design); m_axi_wvalid=0 in W_IDLE.
- B: route by m_axi_bid MSB, strip MSB.
- Counters: rd_cnt[N] +1 on AR handshake from N, -1 on R handshake with rlast to N; both same cycle -> unchanged. wr_cnt[N] +1 on AW handshake, -1 on B handshake. Counter width clog2(MAX_OUTSTANDING+1); saturated counter masks requester, never wraps.
- Simultaneous requests: pointer decides; single request always granted regardless of pointer. Responses are never blocked by arbitration.
- awlen/arlen/size passed unchanged; no burst splitting or 4 KB checks.

Decomposition:
- Package ddr_arb_pkg: requester index type (1 bit), write FSM enum {W_IDLE, W_DATA}, localparams for downstream ID width and counter width function.
- Sub-module ddr_arb_rr: 2-way round-robin with hold input, eligibility inputs, grant index/valid outputs; instantiated once for AR and once for AW.

Test Plan:
- Both arvalid held high, DDR arready=1, single-beat reads -> AR grants alternate s0,s1,s0,s1; m_axi_arid MSB matches; R with rid=7'h45 delivered to s1 with rid 6'h05.
- s1 AW len=3, DDR wready toggling; s0 AW raised mid-burst -> s0 awready stays 0 until s1 wlast handshake, then s0 granted next cycle.
- m_axi_arready=0 for 5 cycles with s0 granted, s1 raises arvalid -> m_axi_araddr/arid stable, grant not switched until handshake.
- MAX_OUTSTANDING=2, s0 issues 3 ARs, no R returned -> third stalls (s0_arready=0); one rlast beat returns -> third accepted next cycle.
- AR handshake and rlast to same requester in one cycle at rd_cnt=1 -> rd_cnt stays 1.
- Assert kcd_reset during W_DATA -> next cycle all valids/readies 0, FSM W_IDLE, counters 0, first post-reset simultaneous AW grants s0.
